// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked parametrised ALU: opcodes, FSM states,
// flag bit positions and a flag-packing helper.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_NE  = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_NEG   = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_CARRY = 3;

  // Place the four status bits at their fixed positions in the flags vector.
  function automatic logic [3:0] pack_flags(input logic carry, input logic ovf,
                                            input logic neg, input logic zero);
    logic [3:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    f[FLAG_NEG]   = neg;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier. The first partial product is folded
// into the start cycle, so done is high WIDTH-1 cycles after start and the
// consumer registering the product on that edge sees it WIDTH edges after start.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               w_done;

  assign w_done  = r_busy && (r_cnt == CNT_W'(WIDTH));
  assign done    = w_done;
  assign product = r_acc;

  // Load operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= B[0] ? {{WIDTH{1'b0}}, A} : '0;
      r_mcand  <= {{(WIDTH-1){1'b0}}, A, 1'b0};
      r_mplier <= B >> 1;
      r_cnt    <= CNT_W'(1);
      r_busy   <= 1'b1;
    end else if (w_done) begin
      r_busy   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_hs_param.sv
// Handshaked WIDTH-bit ALU: single-cycle datapath for all ops except MUL,
// which runs on the iterative multiplier. One result is held in RESP until
// the sink takes it; a new op may be accepted in that same cycle.
module alu_hs_param
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [3:0]       flags
);

  state_e r_state;
  state_e w_state_next;

  logic [WIDTH-1:0]   r_out;
  logic [WIDTH-1:0]   r_hi;
  logic [3:0]         r_flags;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;
  logic [3:0]         w_mul_flags;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_ovf;
  logic [3:0]         w_flags;

  assign in_ready    = (r_state == IDLE) || ((r_state == RESP) && out_ready);
  assign out_valid   = (r_state == RESP);
  assign w_accept    = in_valid && in_ready;
  assign w_is_mul    = (sel == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  assign out   = r_out;
  assign hi    = r_hi;
  assign flags = r_flags;

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .Clk     (Clk),
    .Rst     (Rst),
    .start   (w_mul_start),
    .A       (A),
    .B       (B),
    .done    (w_mul_done),
    .product (w_prod)
  );

  assign w_mul_flags = pack_flags(|w_prod[2*WIDTH-1:WIDTH], 1'b0, w_prod[2*WIDTH-1],
                                  w_prod == '0);

  // Single-cycle result and flags for every op except MUL.
  always_comb begin
    w_sum   = {1'b0, A} + {1'b0, B};
    w_diff  = {1'b0, A} - {1'b0, B};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (sel)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[WIDTH-1:0];
        w_carry = w_diff[WIDTH];  // borrow out
        w_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_NE:   w_res = {{(WIDTH-1){1'b0}}, (A != B)};
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOT:  w_res = ~A;
      default: w_res = '0;  // MUL result comes from the multiplier
    endcase
    w_flags = pack_flags(w_carry, w_ovf, w_res[WIDTH-1], w_res == '0);
  end

  // Next-state logic; any unused encoding falls back to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? MUL : RESP;
        end
      end
      MUL: begin
        if (w_mul_done) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (out_ready) begin
          if (!in_valid) begin
            w_state_next = IDLE;
          end else begin
            w_state_next = w_is_mul ? MUL : RESP;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result registers: load on non-MUL accept or on multiplier completion, else hold.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out   <= '0;
      r_hi    <= '0;
      r_flags <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_out   <= w_res;
      r_hi    <= '0;
      r_flags <= w_flags;
    end else if ((r_state == MUL) && w_mul_done) begin
      r_out   <= w_prod[WIDTH-1:0];
      r_hi    <= w_prod[2*WIDTH-1:WIDTH];
      r_flags <= w_mul_flags;
    end
  end

endmodule

// File: tb/tb_alu_hs_param.sv
// Bench for alu_hs_param at WIDTH=8: directed vector table, hand sequences for
// backpressure / streaming / reset-mid-MUL, and randomized traffic against an
// arithmetic reference model.
module tb_alu_hs_param;

  localparam int W = 8;

  logic         Clk;
  logic         Rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [W-1:0] hi;
  logic [3:0]   flags;

  int n_vec = 0;
  int n_err = 0;
  int stalls = 0;

  typedef struct {
    logic [2:0]   s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic [3:0]   f;
  } vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic [3:0]   f;
  } res_t;

  vec_t       vecs[13];
  res_t       exp_q[$];
  logic [2:0] op_s[$];
  logic [W-1:0] op_a[$];
  logic [W-1:0] op_b[$];

  alu_hs_param #(
    .WIDTH (W)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .hi        (hi),
    .flags     (flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: result of one op from the arithmetic definitions.
  function automatic res_t model(input logic [2:0] s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t   r;
    longint m  = longint'(1) << W;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = a[W-1] ? ua - m : ua;
    longint sb = b[W-1] ? ub - m : ub;
    longint t  = 0;
    longint st = 0;
    logic   c  = 1'b0;
    logic   v  = 1'b0;
    logic   n, z;
    r.o = '0;
    r.h = '0;
    case (s)
      3'd0: begin
        t = ua + ub; r.o = W'(t); c = (t >= m);
        st = sa + sb; v = (st > m / 2 - 1) || (st < -(m / 2));
      end
      3'd1: begin
        t = ua - ub; r.o = W'(t); c = (ua < ub);
        st = sa - sb; v = (st > m / 2 - 1) || (st < -(m / 2));
      end
      3'd2: begin
        t = ua * ub; r.o = W'(t); r.h = W'(t >> W); c = (r.h != 0);
      end
      3'd3: r.o = (a != b) ? W'(1) : W'(0);
      3'd4: r.o = a & b;
      3'd5: r.o = a | b;
      3'd6: r.o = a ^ b;
      default: r.o = ~a;
    endcase
    n = (s == 3'd2) ? r.h[W-1] : r.o[W-1];
    z = (s == 3'd2) ? (t == 0) : (r.o == 0);
    r.f = {c, v, n, z};
    return r;
  endfunction

  // One op from IDLE with out_ready=1; returns edges from accept to out_valid.
  task automatic do_op(input logic [2:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat);
    int busy_ready;
    in_valid  = 1'b1;
    sel       = s;
    A         = a;
    B         = b;
    out_ready = 1'b1;
    #1;
    chk("accept_in_ready", int'(in_ready), 1);
    @(posedge Clk); #1;
    in_valid   = 1'b0;
    A          = W'($urandom);
    B          = W'($urandom);
    sel        = 3'($urandom);
    lat        = -1;
    busy_ready = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) busy_ready = 1;
      @(posedge Clk); #1;
    end
    chk("busy_in_ready", busy_ready, 0);
  endtask

  // Streams op_* through the DUT; called and returns at posedge+1.
  task automatic run_stream(input bit rnd, input int budget);
    int   idx = 0;
    int   got = 0;
    int   cyc = 0;
    int   total = op_s.size();
    bit   pending = 1'b0;
    res_t e;
    stalls = 0;
    while (got < total && cyc < budget) begin
      if (!pending && idx < total && (!rnd || $urandom_range(0, 9) < 7)) begin
        in_valid = 1'b1;
        sel      = op_s[idx];
        A        = op_a[idx];
        B        = op_b[idx];
        pending  = 1'b1;
      end else if (!pending) begin
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        sel      = 3'($urandom);
      end
      out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      #1;
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(sel, A, B));
        pending = 1'b0;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL stream_extra: got result 0x%0h, expected no result", out);
        end else begin
          e = exp_q.pop_front();
          chk("stream_out", int'(out), int'(e.o));
          chk("stream_hi", int'(hi), int'(e.h));
          chk("stream_flags", int'(flags), int'(e.f));
          got++;
        end
      end
      @(posedge Clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", got, total);
  endtask

  initial begin
    int   lat;
    int   seen;
    res_t r;

    vecs[0]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b1001};
    vecs[1]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0100};
    vecs[2]  = '{3'd1, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b1010};
    vecs[3]  = '{3'd2, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1010};
    vecs[4]  = '{3'd4, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000};
    vecs[5]  = '{3'd5, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0010};
    vecs[6]  = '{3'd6, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001};
    vecs[7]  = '{3'd7, 8'h0F, 8'h55, 8'hF0, 8'h00, 4'b0010};
    vecs[8]  = '{3'd3, 8'h05, 8'h05, 8'h00, 8'h00, 4'b0001};
    vecs[9]  = '{3'd3, 8'h05, 8'h06, 8'h01, 8'h00, 4'b0000};
    vecs[10] = '{3'd2, 8'h10, 8'h10, 8'h00, 8'h01, 4'b1000};
    vecs[11] = '{3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b0110};
    vecs[12] = '{3'd2, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0001};

    Rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    sel       = '0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out", int'(out), 0);
    chk("reset_hi", int'(hi), 0);
    chk("reset_flags", int'(flags), 0);

    // Directed table, one op at a time.
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      chk("vec_latency", lat, (vecs[i].s == 3'd2) ? W : 0);
      chk("vec_out", int'(out), int'(vecs[i].o));
      chk("vec_hi", int'(hi), int'(vecs[i].h));
      chk("vec_flags", int'(flags), int'(vecs[i].f));
      @(posedge Clk); #1;
      chk("vec_valid_drop", int'(out_valid), 0);
    end

    // Backpressure: result held while the sink stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 3'd4;
    A         = 8'hF0;
    B         = 8'h3C;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_out", int'(out), 8'h30);
      chk("bp_in_ready", int'(in_ready), 0);
      @(posedge Clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    @(posedge Clk); #1;
    chk("bp_done_valid", int'(out_valid), 0);

    // Streaming: all eight opcodes back to back, zero operands for MUL/NE.
    op_s.delete(); op_a.delete(); op_b.delete();
    for (int i = 0; i < 8; i++) begin
      op_s.push_back(3'(i));
      op_a.push_back((i == 2 || i == 3) ? 8'h00 : W'(8'hA5 + 8'(i)));
      op_b.push_back((i == 2 || i == 3) ? 8'h00 : W'(8'h3C - 8'(i)));
    end
    run_stream(1'b0, 100);
    chk("stream_stalls", stalls, W);
    chk("stream_idle", int'(out_valid), 0);

    // Randomized traffic with random gaps and sink stalls.
    op_s.delete(); op_a.delete(); op_b.delete();
    for (int i = 0; i < 200; i++) begin
      op_s.push_back(3'($urandom));
      op_a.push_back(W'($urandom));
      op_b.push_back(W'($urandom));
    end
    run_stream(1'b1, 4000);

    // Reset in the middle of a MUL; the product must never surface.
    do_op(3'd5, 8'hF0, 8'h0F, lat);
    chk("pre_reset_out", int'(out), 8'hFF);
    @(posedge Clk); #1;
    in_valid = 1'b1;
    sel      = 3'd2;
    A        = 8'hFF;
    B        = 8'hFF;
    @(posedge Clk); #1;
    sel = 3'd0;
    A   = 8'h01;
    B   = 8'h01;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;  // in_valid still high: reset must win over the handshake
    @(posedge Clk); #1;
    Rst      = 1'b0;
    in_valid = 1'b0;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out", int'(out), 0);
    chk("abort_hi", int'(hi), 0);
    chk("abort_flags", int'(flags), 0);
    chk("abort_in_ready", int'(in_ready), 1);
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen = 1;
      @(posedge Clk); #1;
    end
    chk("abort_no_result", seen, 0);

    // Multiplier must be usable again after the abort.
    do_op(3'd2, 8'hC3, 8'h5A, lat);
    r = model(3'd2, 8'hC3, 8'h5A);
    chk("post_reset_latency", lat, W);
    chk("post_reset_out", int'(out), int'(r.o));
    chk("post_reset_hi", int'(hi), int'(r.h));
    chk("post_reset_flags", int'(flags), int'(r.f));
    @(posedge Clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
